// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the F/D/E/M/W pipeline: load-use, mul/div occupancy, memory wait, exception redirect.
// Optional HAZARD_PERF_CNT_EN adds perfStallCycles / perfFlushEvents counters.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             useRsD,
    input  logic             useRtD,
    input  logic             memReadE,
    input  logic             regWriteE,
    input  logic [4:0]       writeRegE,
    input  logic             mdStartE,
    input  logic             isDivE,
    input  logic             iWait,
    input  logic             dWait,
    input  logic             exceptionM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             mdBusy,
    output logic             mdAbort,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      perfStallCycles,
    output logic [31:0]      perfFlushEvents,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        EXC_KILL = 2'd2
    } state_t;

    // The start cycle is itself a stall cycle, so the counter holds the remaining MD_WAIT cycles (L-2).
    localparam logic [CNT_W-1:0] MUL_LD = (MUL_CYCLES > 2) ? CNT_W'(MUL_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_LD = (DIV_CYCLES > 2) ? CNT_W'(DIV_CYCLES - 2) : '0;
    localparam logic MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic MUL_WAIT  = (MUL_CYCLES > 2);
    localparam logic DIV_WAIT  = (DIV_CYCLES > 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_run, in_wait, in_kill;
    logic md_start, load_use;

    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        mdAbort  = 1'b0;

        in_run   = (state_q == RUN);
        in_wait  = (state_q == MD_WAIT);
        in_kill  = (state_q == EXC_KILL);
        md_start = in_run & mdStartE & (isDivE ? DIV_MULTI : MUL_MULTI);
        mdBusy   = in_wait | md_start;
        load_use = memReadE & regWriteE & (writeRegE != 5'd0) &
                   ((useRsD & (rsD == writeRegE)) | (useRtD & (rtD == writeRegE)));

        if (exceptionM) begin
            flushD  = 1'b1;
            flushE  = 1'b1;
            flushM  = 1'b1;
            mdAbort = in_wait | (in_run & mdStartE);
            state_d = EXC_KILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (md_start) begin
                        cnt_d   = isDivE ? DIV_LD : MUL_LD;
                        state_d = (isDivE ? DIV_WAIT : MUL_WAIT) ? MD_WAIT : RUN;
                    end
                end
                MD_WAIT: begin
                    // Self-timed: keeps counting through dWait.
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    if (cnt_d == '0) state_d = RUN;
                end
                default: state_d = RUN;
            endcase

            if (dWait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end
            if (mdBusy) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = ~stallM;
            end
            if (load_use && !dWait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = ~stallE;
            end
            if (iWait && !dWait) begin
                stallF = 1'b1;
                flushD = ~stallD;
            end
            // The wrong-path instruction fetched during the redirect must go, even if D is held.
            if (in_kill) begin
                flushD = 1'b1;
                stallD = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stallF};
        perf_flush_d = perf_flush_q + {31'd0, exceptionM};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perfStallCycles = perf_stall_q;
    assign perfFlushEvents = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-by-cycle reference model plus directed vectors with literal expectations.
module tb_hazard_ctrl;

    localparam int MUL_C = 3;
    localparam int DIV_C = 34;

    logic clk = 1'b0;
    logic resetn;
    logic [4:0] rsD, rtD, writeRegE;
    logic useRsD, useRtD, memReadE, regWriteE, mdStartE, isDivE, iWait, dWait, exceptionM;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mdBusy, mdAbort;
    logic [1:0] dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perfStallCycles, perfFlushEvents;
`endif

    logic [9:0] outs;
    assign outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mdBusy, mdAbort};

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .memReadE(memReadE), .regWriteE(regWriteE), .writeRegE(writeRegE),
        .mdStartE(mdStartE), .isDivE(isDivE),
        .iWait(iWait), .dWait(dWait), .exceptionM(exceptionM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mdBusy(mdBusy), .mdAbort(mdAbort),
`ifdef HAZARD_PERF_CNT_EN
        .perfStallCycles(perfStallCycles), .perfFlushEvents(perfFlushEvents),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: multi-cycle ops tracked as an absolute last-busy cycle
    int  cyc       = 0;
    int  busy_last = -1;
    int  kill_cyc  = -1;
    bit  model_on  = 0;

    always @(negedge clk) begin
        int len;
        logic in_wait, in_kill, start, lu, sd_raw;
        logic [9:0] e;
        len     = isDivE ? DIV_C : MUL_C;
        in_wait = (cyc <= busy_last);
        in_kill = (cyc == kill_cyc);
        start   = !in_wait && !in_kill && mdStartE && (len > 1);
        lu      = memReadE && regWriteE && (writeRegE != 0) &&
                  ((useRsD && rsD == writeRegE) || (useRtD && rtD == writeRegE));
        e = '0;
        e[1] = in_wait || start;
        if (exceptionM) begin
            e[5] = 1; e[4] = 1; e[3] = 1;
            e[0] = in_wait || (!in_kill && mdStartE);
        end else begin
            sd_raw = dWait || e[1] || (lu && !dWait);
            e[6] = dWait;
            e[2] = dWait;
            e[7] = dWait || e[1];
            e[9] = sd_raw || (iWait && !dWait);
            e[3] = e[1] && !dWait;
            e[4] = lu && !dWait && !e[7];
            e[5] = in_kill || (iWait && !dWait && !sd_raw);
            e[8] = sd_raw && !in_kill;
        end
        if (model_on) chk("cycle_outs", {22'd0, outs}, {22'd0, e});
        if (!resetn) begin
            busy_last = -1;
            kill_cyc  = -1;
            model_on  = 1;
        end else if (exceptionM) begin
            busy_last = -1;
            kill_cyc  = cyc + 1;
        end else if (start) begin
            busy_last = cyc + len - 2;
        end
        cyc++;
    end

    // driver tasks
    task automatic idle();
        rsD = 0; rtD = 0; writeRegE = 0; useRsD = 0; useRtD = 0;
        memReadE = 0; regWriteE = 0; mdStartE = 0; isDivE = 0;
        iWait = 0; dWait = 0; exceptionM = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    logic [9:0] mul_exp [5];

    initial begin
        mul_exp = '{10'b1110_0010_10, 10'b1111_0001_10, 10'b1111_0001_00, 10'b0, 10'b0};
        idle();
        resetn = 0;
        nxt(); nxt();
        resetn = 1;
        mid(); chk("reset_outs", {22'd0, outs}, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("reset_perf_stall", perfStallCycles, 0);
        chk("reset_perf_flush", perfFlushEvents, 0);
`endif

        // load-use
        nxt(); memReadE = 1; regWriteE = 1; writeRegE = 5; useRsD = 1; rsD = 5;
        mid(); chk("lu_rs", {22'd0, outs}, 10'b1100_0100_00);
        nxt(); writeRegE = 0; rsD = 0;
        mid(); chk("lu_r0", {22'd0, outs}, 0);
        nxt(); writeRegE = 7; useRsD = 0; rsD = 7; rtD = 7;
        mid(); chk("lu_nouse", {22'd0, outs}, 0);
        nxt(); useRtD = 1;
        mid(); chk("lu_rt", {22'd0, outs}, 10'b1100_0100_00);
        nxt(); memReadE = 0;
        mid(); chk("lu_noload", {22'd0, outs}, 0);

        // divide: stall t..t+32
        for (int k = 0; k < 35; k++) begin
            nxt(); idle(); isDivE = 1; mdStartE = (k == 0);
            mid();
            chk("div_stall_e", {31'd0, stallE}, {31'd0, (k <= 32)});
            chk("div_busy", {31'd0, mdBusy}, {31'd0, (k <= 32)});
        end

        // multiply with a 2-cycle dWait: counter keeps running
        for (int k = 0; k < 5; k++) begin
            nxt(); idle(); mdStartE = (k == 0); dWait = (k == 1 || k == 2);
            mid(); chk("mul_dwait", {22'd0, outs}, {22'd0, mul_exp[k]});
        end

        // exception during a divide
        for (int k = 0; k < 13; k++) begin
            nxt(); idle(); isDivE = 1; mdStartE = (k == 0); exceptionM = (k == 10);
            mid();
            if (k == 10) chk("exc_md_wait", {22'd0, outs}, 10'b0000_1110_11);
            if (k == 11) chk("exc_kill", {22'd0, outs}, 10'b0000_1000_00);
            if (k == 12) chk("exc_after", {22'd0, outs}, 0);
        end

        // exception coincident with a mul/div start in RUN
        nxt(); idle(); mdStartE = 1; exceptionM = 1;
        mid(); chk("exc_start", {22'd0, outs}, 10'b0000_1110_11);
        nxt(); exceptionM = 0;
        mid(); chk("exc_start_kill", {22'd0, outs}, 10'b0000_1000_00);
        nxt(); idle();
        mid(); chk("exc_start_after", {22'd0, outs}, 0);

        // back-to-back exceptions
        nxt(); exceptionM = 1;
        mid(); chk("exc_b2b_0", {22'd0, outs}, 10'b0000_1110_00);
        nxt();
        mid(); chk("exc_b2b_1", {22'd0, outs}, 10'b0000_1110_00);
        nxt(); exceptionM = 0;
        mid(); chk("exc_b2b_kill", {22'd0, outs}, 10'b0000_1000_00);
        nxt();
        mid(); chk("exc_b2b_run", {22'd0, outs}, 0);

        // iWait alone, then with load-use, then masked by dWait
        for (int k = 0; k < 3; k++) begin
            nxt(); idle(); iWait = 1;
            mid(); chk("iwait", {22'd0, outs}, 10'b1000_1000_00);
        end
        nxt(); memReadE = 1; regWriteE = 1; writeRegE = 9; useRtD = 1; rtD = 9;
        mid(); chk("iwait_lu", {22'd0, outs}, 10'b1100_0100_00);
        nxt(); dWait = 1;
        mid(); chk("dwait_mask", {22'd0, outs}, 10'b1111_0001_00);

        // iWait while a multiply holds D
        nxt(); idle(); mdStartE = 1; iWait = 1;
        mid(); chk("iwait_md", {22'd0, outs}, 10'b1110_0010_10);
        nxt(); idle();
        mid(); chk("iwait_md_wait", {22'd0, outs}, 10'b1110_0010_10);
        nxt();
        mid(); chk("iwait_md_done", {22'd0, outs}, 0);

`ifdef HAZARD_PERF_CNT_EN
        nxt(); resetn = 0;
        nxt(); resetn = 1; iWait = 1;
        nxt(); nxt(); nxt(); idle(); exceptionM = 1;
        nxt(); exceptionM = 0;
        mid();
        chk("perf_stall", perfStallCycles, 3);
        chk("perf_flush", perfFlushEvents, 1);
`endif

        // reset while in MD_WAIT
        for (int k = 0; k < 6; k++) begin
            nxt(); idle(); isDivE = 1; mdStartE = (k == 0);
        end
        resetn = 0;
        nxt(); resetn = 1; idle();
        mid();
        chk("rst_md_outs", {22'd0, outs}, 0);
        chk("rst_md_abort", {31'd0, mdAbort}, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_perf_stall", perfStallCycles, 0);
        chk("rst_perf_flush", perfFlushEvents, 0);
`endif
        nxt(); nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
